pool_max_row: RTL

//  Streaming max-pooling stage directly downstream of PU: consumes one output pixel per beat
//  (NUM_PE lanes = NUM_PE output channels, same x/y position) in raster order, applies
//  KxK max pooling with stride 2 (K = 2 or 3) per lane, and emits pooled pixels.

---
 rtl/pool_max_row.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pool_max_row.sv
// Streaming KxK (K=2/3) stride-2 max pooling over NUM_PE independent lanes, with bypass.
// Stage 1 reduces each window horizontally; stage 2 reduces it vertically against a row buffer.
module pool_max_row #(
  parameter int unsigned NUM_PE            = 4,
  parameter int unsigned OP_WIDTH          = 16,
  parameter int unsigned LAYER_PARAM_WIDTH = 10,
  parameter int unsigned MAX_OW            = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         cfg_pool_en,
  input  logic [1:0]                   cfg_kernel,
  input  logic [LAYER_PARAM_WIDTH-1:0] cfg_iw_m1,
  input  logic [LAYER_PARAM_WIDTH-1:0] cfg_ih_m1,
  input  logic                         in_valid,
  input  logic [NUM_PE*OP_WIDTH-1:0]   in_data,
  output logic                         out_valid,
  output logic [NUM_PE*OP_WIDTH-1:0]   out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);
  localparam int unsigned DW   = NUM_PE * OP_WIDTH;
  localparam int unsigned LPW  = LAYER_PARAM_WIDTH;
  localparam int unsigned LPW1 = LAYER_PARAM_WIDTH + 1;
  localparam int unsigned JW   = (MAX_OW > 1) ? $clog2(MAX_OW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Vertical action for a horizontal result: seed the buffer, fold into it, or emit and reseed.
  localparam logic [1:0] V_WR   = 2'd0;
  localparam logic [1:0] V_ACC  = 2'd1;
  localparam logic [1:0] V_EMIT = 2'd2;

  function automatic logic [DW-1:0] lane_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] m;
    m = b;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if ($signed(a[i*OP_WIDTH +: OP_WIDTH]) > $signed(b[i*OP_WIDTH +: OP_WIDTH]))
        m[i*OP_WIDTH +: OP_WIDTH] = a[i*OP_WIDTH +: OP_WIDTH];
    end
    return m;
  endfunction

  logic [1:0]     state_q, state_d;
  logic           flush_q, flush_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pool_en_q, pool_en_d;
  logic           k3_q, k3_d;
  logic [LPW-1:0] iw_m1_q, iw_m1_d;
  logic [LPW-1:0] ih_m1_q, ih_m1_d;
  logic [LPW-1:0] c_q, c_d;
  logic [LPW-1:0] r_q, r_d;

  logic [DW-1:0]  h_q, h_d;
  logic           s1_valid_q, s1_valid_d;
  logic [DW-1:0]  s1_data_q, s1_data_d;
  logic [JW-1:0]  s1_j_q, s1_j_d;
  logic [1:0]     s1_mode_q, s1_mode_d;
  logic           s1_last_q, s1_last_d;
  logic           s1_byp_q, s1_byp_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic           out_last_q, out_last_d;

  logic [DW-1:0]  row_buf_q [MAX_OW];

  logic           accept_c, col_end_c, last_beat_c, pool_last_c;
  logic           h_emit_c;
  logic [LPW-1:0] j_full_c;
  logic [1:0]     v_mode_c;
  logic [DW-1:0]  hmax_c, buf_rd_c, vmax_c, buf_wd_c;
  logic           buf_we_c;

  assign accept_c    = (state_q == S_RUN) && in_valid;
  assign col_end_c   = (c_q == iw_m1_q);
  assign last_beat_c = col_end_c && (r_q == ih_m1_q);
  // A window is the last of its row/column when the next one (two further on) cannot complete.
  assign pool_last_c = (({1'b0, c_q} + LPW1'(2)) > {1'b0, iw_m1_q}) &&
                       (({1'b0, r_q} + LPW1'(2)) > {1'b0, ih_m1_q});

  assign hmax_c   = lane_max(h_q, in_data);
  assign buf_rd_c = row_buf_q[s1_j_q];
  assign vmax_c   = lane_max(buf_rd_c, s1_data_q);

  // Frame sequencing, config latch and raster position counters.
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    done_d    = 1'b0;
    pool_en_d = pool_en_q;
    k3_d      = k3_q;
    iw_m1_d   = iw_m1_q;
    ih_m1_d   = ih_m1_q;
    c_d       = c_q;
    r_d       = r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          pool_en_d = cfg_pool_en;
          k3_d      = (cfg_kernel == 2'd3);
          iw_m1_d   = cfg_iw_m1;
          ih_m1_d   = cfg_ih_m1;
          c_d       = '0;
          r_d       = '0;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          if (col_end_c) begin
            c_d = '0;
            r_d = r_q + LPW'(1);
          end else begin
            c_d = c_q + LPW'(1);
          end
          if (last_beat_c) begin
            state_d = S_FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Stage 1: horizontal window reduction and vertical action selection.
  always_comb begin
    h_d        = h_q;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    s1_j_d     = s1_j_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = 1'b0;
    s1_byp_d   = s1_byp_q;
    h_emit_c   = 1'b0;
    j_full_c   = '0;
    v_mode_c   = V_WR;
    if (accept_c) begin
      if (!pool_en_q) begin
        s1_valid_d = 1'b1;
        s1_byp_d   = 1'b1;
        s1_data_d  = in_data;
        s1_last_d  = last_beat_c;
      end else begin
        if (k3_q) begin
          h_emit_c = !c_q[0] && (c_q != '0);
          j_full_c = (c_q >> 1) - LPW'(1);
          h_d      = c_q[0] ? hmax_c : in_data;
          if (r_q == '0)
            v_mode_c = V_WR;
          else if (r_q[0])
            v_mode_c = V_ACC;
          else
            v_mode_c = V_EMIT;
        end else begin
          h_emit_c = c_q[0];
          j_full_c = c_q >> 1;
          if (!c_q[0])
            h_d = in_data;
          v_mode_c = r_q[0] ? V_EMIT : V_WR;
        end
        if (h_emit_c && (32'(j_full_c) < MAX_OW)) begin
          s1_valid_d = 1'b1;
          s1_byp_d   = 1'b0;
          s1_data_d  = hmax_c;
          s1_j_d     = JW'(j_full_c);
          s1_mode_d  = v_mode_c;
          s1_last_d  = pool_last_c;
        end
      end
    end
  end

  // Stage 2: vertical reduction against the row buffer, or straight forward in bypass.
  always_comb begin
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = out_data_q;
    buf_we_c    = 1'b0;
    buf_wd_c    = s1_data_q;
    if (s1_valid_q) begin
      if (s1_byp_q) begin
        out_valid_d = 1'b1;
        out_data_d  = s1_data_q;
        out_last_d  = s1_last_q;
      end else begin
        case (s1_mode_q)
          V_WR: buf_we_c = 1'b1;
          V_ACC: begin
            buf_we_c = 1'b1;
            buf_wd_c = vmax_c;
          end
          default: begin
            buf_we_c    = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = vmax_c;
            out_last_d  = s1_last_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pool_en_q <= 1'b0;
      k3_q      <= 1'b0;
      iw_m1_q   <= '0;
      ih_m1_q   <= '0;
      c_q       <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pool_en_q <= pool_en_d;
      k3_q      <= k3_d;
      iw_m1_q   <= iw_m1_d;
      ih_m1_q   <= ih_m1_d;
      c_q       <= c_d;
      r_q       <= r_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_j_q      <= '0;
      s1_mode_q   <= V_WR;
      s1_last_q   <= 1'b0;
      s1_byp_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      h_q         <= h_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_j_q      <= s1_j_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_byp_q    <= s1_byp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Row buffer contents are always seeded by the first window row of a frame, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we_c)
      row_buf_q[s1_j_q] <= buf_wd_c;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
